gesture_lock_fsm: RTL and testbench
===================================

GESTURE_LOCK_FSM -- requirements
Module: gesture_lock_fsm

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000; input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100; FSM tick rate in Hz; divider = CLK_HZ/TICK_HZ, which SHALL be at least 2.
REQ-003 Parameter SEQ_LEN, default 4; number of gesture steps, 2..8.
REQ-004 Parameter PATTERN, 2*SEQ_LEN bits, default 8'b00_11_01_11; step k occupies bits [2k+1:2k], so the default sequence is 11, 01, 11, 00.
REQ-005 Parameter DEBOUNCE_TICKS, default 2; ticks a hand value must stay stable before it is accepted.
REQ-006 Parameter ARM_TICKS, default 50; length of the ARM phase in ticks.
REQ-007 Parameter OPEN_TICKS, default 300; length of the OPEN phase in ticks.
REQ-008 Parameter FAIL_TICKS, default 100; length of the FAIL phase in ticks.
REQ-009 Parameter STEP_TIMEOUT_TICKS, default 500; maximum ticks allowed between accepted steps.
REQ-010 clk  input  1  system clock; the only clock; all state changes on posedge clk.
REQ-011 reset  input  1  asynchronous, active-high reset.
REQ-012 hand  input  2  raw hand-sensor bits, asynchronous to clk.
REQ-013 r  output  1  red LED.
REQ-014 g  output  1  green LED.
REQ-015 unlock  output  1  one-clk pulse on entry to OPEN.
REQ-016 step  output  3  index of the next expected pattern step.

Function
REQ-017 hand SHALL pass through a 2-flop synchroniser before any use.
REQ-018 A single-cycle tick enable SHALL assert once every CLK_HZ/TICK_HZ clk cycles; no derived clocks are used.
REQ-019 Debounce: the accepted value dh SHALL update only after the synchronised value has been stable for DEBOUNCE_TICKS consecutive ticks.
REQ-020 A change of dh SHALL produce a one-cycle "event".
REQ-021 FSM states SHALL be IDLE, MATCH, ARM, OPEN and FAIL.
REQ-022 IDLE: r=1, g=0, step=0; an event with dh==PATTERN[0] SHALL advance to MATCH with step=1; all other events are ignored.
REQ-023 MATCH: r=0, g=0.
- Event with dh==PATTERN[step], step<SEQ_LEN-1: step increments.
- Event with dh==PATTERN[step], step==SEQ_LEN-1: go to ARM.
- Event with any other dh: go to FAIL.
REQ-024 ARM: r=1, g=0; after ARM_TICKS ticks go to OPEN; hand is ignored.
REQ-025 OPEN: r=0, g=1; unlock=1 on the first clk of OPEN only; after OPEN_TICKS ticks go to IDLE.
REQ-026 FAIL: g=0; r toggles every tick, starting at 1; after FAIL_TICKS ticks go to IDLE with step=0.
REQ-027 Phase counter: reset to 0 on every state entry; increments on tick; exit occurs on the tick where count==N-1, giving exactly N ticks per phase.
REQ-028 Counter widths SHALL be $clog2 of the largest tick parameter plus 1; no wrap is possible within a phase.
REQ-029 Simultaneous tick and event: the event is evaluated against the state before the tick-driven transition; at most one transition per clk.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 Reset assertion SHALL force: IDLE, step=0, r=1, g=0, unlock=0, all counters 0, synchroniser and dh cleared to 2'b00.
REQ-032 Reset mid-phase (ARM, OPEN or FAIL) SHALL abort immediately with no unlock pulse; operation resumes on the first clk after deassertion.

Configuration
REQ-033 Macro GESTURE_LOCK_TIMEOUT_EN defined: in MATCH, STEP_TIMEOUT_TICKS ticks without an accepted step SHALL go to FAIL; the counter restarts on each accepted step.
REQ-034 Macro GESTURE_LOCK_TIMEOUT_EN undefined: MATCH has no timeout; STEP_TIMEOUT_TICKS is unused; no timeout logic is synthesised.

Structure
REQ-035 Package gesture_lock_pkg SHALL hold the state enum (IDLE, MATCH, ARM, OPEN, FAIL) and the hand-code constants HAND_NONE=2'b00, HAND_L=2'b01, HAND_R=2'b10, HAND_BOTH=2'b11.
REQ-036 Sub-module tick_gen (parameters CLK_HZ and TICK_HZ; ports clk, reset, tick) SHALL generate the tick enable.

Verification (bench parameters CLK_HZ=1000, TICK_HZ=100, DEBOUNCE=2, ARM=5, OPEN=10, FAIL=4, TIMEOUT=20, default PATTERN)
REQ-037 Hand sequence 11,01,11,00, each held 5 ticks -> ARM with r=1 for 5 ticks -> unlock pulses exactly 1 clk, g=1 for 10 ticks (100 clk) -> IDLE with r=1.
REQ-038 11, then 10 -> FAIL, r toggles 4 ticks -> IDLE with step=0; no unlock.
REQ-039 In IDLE, a 1-tick glitch on hand to 11 -> no event; step stays 0.
REQ-040 With GESTURE_LOCK_TIMEOUT_EN: 11, then hold 21 ticks -> FAIL at tick 20; without the macro -> remains in MATCH with step=1.
REQ-041 Reset asserted at OPEN tick 3 -> same-cycle r=1, g=0, IDLE; after release, the full sequence unlocks normally.
REQ-042 Event coincident with the ARM exit tick -> transition to OPEN only; the event has no effect.

Source files
------------

// File: rtl/gesture_lock_pkg.sv
// rtl/gesture_lock_pkg.sv - shared types and constants for the gesture lock
//
// Purpose : FSM state enum, hand-sensor codes and a small elaboration helper.
// Ports   : none (package).
// Config  : none here; GESTURE_LOCK_TIMEOUT_EN is consumed by gesture_lock_fsm.

package gesture_lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MATCH,
    ARM,
    OPEN,
    FAIL
  } state_t;

  localparam logic [1:0] HAND_NONE = 2'b00;
  localparam logic [1:0] HAND_L    = 2'b01;
  localparam logic [1:0] HAND_R    = 2'b10;
  localparam logic [1:0] HAND_BOTH = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gesture_lock_tick_gen.sv
// rtl/gesture_lock_tick_gen.sv - single-cycle tick enable every CLK_HZ/TICK_HZ clocks
//
// Purpose : free-running divider producing a one-clk enable; no derived clock.
// Ports   : clk   - system clock
//           reset - asynchronous active-high reset
//           tick  - registered one-cycle enable, period CLK_HZ/TICK_HZ (>= 2)

module tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/gesture_lock_fsm.sv
// rtl/gesture_lock_fsm.sv - gesture-sequence lock with debounced hand sensor
//
// Purpose : synchronise and debounce a 2-bit hand sensor, match it against
//           PATTERN, then run ARM -> OPEN (unlock) or FAIL timed phases.
// Ports   : clk    - system clock
//           reset  - asynchronous active-high reset
//           hand   - raw 2-bit hand sensor (asynchronous)
//           r, g   - red / green LEDs (registered)
//           unlock - one-clk pulse on entry to OPEN (registered)
//           step   - index of next expected pattern step (registered)
// Config  : `define GESTURE_LOCK_TIMEOUT_EN adds a STEP_TIMEOUT_TICKS limit
//           between accepted steps while in MATCH.

module gesture_lock_fsm
  import gesture_lock_pkg::*;
#(
  parameter int                   CLK_HZ             = 100_000_000,
  parameter int                   TICK_HZ            = 100,
  parameter int                   SEQ_LEN            = 4,
  parameter logic [2*SEQ_LEN-1:0] PATTERN            = 8'b00_11_01_11,
  parameter int                   DEBOUNCE_TICKS     = 2,
  parameter int                   ARM_TICKS          = 50,
  parameter int                   OPEN_TICKS         = 300,
  parameter int                   FAIL_TICKS         = 100,
  parameter int                   STEP_TIMEOUT_TICKS = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] hand,
  output logic       r,
  output logic       g,
  output logic       unlock,
  output logic [2:0] step
);

  localparam int MAX_TICKS = max_int(max_int(max_int(DEBOUNCE_TICKS, ARM_TICKS),
                                             max_int(OPEN_TICKS, FAIL_TICKS)),
                                     STEP_TIMEOUT_TICKS);
  localparam int CNT_W = $clog2(MAX_TICKS) + 1;

  localparam logic [CNT_W-1:0] DEB_N     = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_TICKS - 1);
  localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_TICKS - 1);
  localparam logic [CNT_W-1:0] FAIL_LAST = CNT_W'(FAIL_TICKS - 1);
`ifdef GESTURE_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(STEP_TIMEOUT_TICKS - 1);
`endif
  localparam logic [2:0] LAST_STEP = 3'(SEQ_LEN - 1);

  logic tick;

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Synchroniser and tick-sampled debounce.
  logic [1:0]       sync1, sync2, dh, last_smp;
  logic [CNT_W-1:0] stable_cnt, stable_nxt;
  logic             hand_evt;
  logic [1:0]       exp_hand;

  // The event is raised in the same cycle as the accepting tick, so the FSM
  // sees the new value (sync2) together with that tick.
  always_comb begin
    stable_nxt = stable_cnt;
    if (sync2 != last_smp) begin
      stable_nxt = CNT_W'(1);
    end else if (stable_cnt < DEB_N) begin
      stable_nxt = stable_cnt + CNT_W'(1);
    end
    hand_evt = tick && (stable_nxt >= DEB_N) && (sync2 != dh);
  end

  assign exp_hand = PATTERN[2*step +: 2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= HAND_NONE;
      sync2      <= HAND_NONE;
      last_smp   <= HAND_NONE;
      dh         <= HAND_NONE;
      stable_cnt <= '0;
    end else begin
      sync1 <= hand;
      sync2 <= sync1;
      if (tick) begin
        last_smp   <= sync2;
        stable_cnt <= stable_nxt;
      end
      if (hand_evt) begin
        dh <= sync2;
      end
    end
  end

  state_t           state;
  logic [CNT_W-1:0] phase_cnt;

  // In IDLE/MATCH an event wins over any tick-driven action; in the timed
  // phases events are ignored, so at most one transition happens per clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      step      <= 3'd0;
      r         <= 1'b1;
      g         <= 1'b0;
      unlock    <= 1'b0;
      phase_cnt <= '0;
    end else begin
      unlock <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hand_evt && sync2 == PATTERN[1:0]) begin
            state     <= MATCH;
            step      <= 3'd1;
            r         <= 1'b0;
            phase_cnt <= '0;
          end
        end
        MATCH: begin
          if (hand_evt) begin
            phase_cnt <= '0;
            if (sync2 == exp_hand) begin
              if (step == LAST_STEP) begin
                state <= ARM;
                r     <= 1'b1;
              end else begin
                step <= step + 3'd1;
              end
            end else begin
              state <= FAIL;
              r     <= 1'b1;
            end
          end
`ifdef GESTURE_LOCK_TIMEOUT_EN
          else if (tick) begin
            if (phase_cnt == TO_LAST) begin
              state     <= FAIL;
              r         <= 1'b1;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt + CNT_W'(1);
            end
          end
`endif
        end
        ARM: begin
          if (tick) begin
            if (phase_cnt == ARM_LAST) begin
              state     <= OPEN;
              r         <= 1'b0;
              g         <= 1'b1;
              unlock    <= 1'b1;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt + CNT_W'(1);
            end
          end
        end
        OPEN: begin
          if (tick) begin
            if (phase_cnt == OPEN_LAST) begin
              state     <= IDLE;
              r         <= 1'b1;
              g         <= 1'b0;
              step      <= 3'd0;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt + CNT_W'(1);
            end
          end
        end
        FAIL: begin
          if (tick) begin
            if (phase_cnt == FAIL_LAST) begin
              state     <= IDLE;
              r         <= 1'b1;
              step      <= 3'd0;
              phase_cnt <= '0;
            end else begin
              r         <= ~r;
              phase_cnt <= phase_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          step      <= 3'd0;
          r         <= 1'b1;
          g         <= 1'b0;
          phase_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gesture_lock_fsm.sv
// tb/tb_gesture_lock_fsm.sv - self-checking bench for gesture_lock_fsm

module tb_gesture_lock_fsm;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int SEQ_LEN = 4;
  localparam int DEB     = 2;
  localparam int ARM_T   = 5;
  localparam int OPEN_T  = 10;
  localparam int FAIL_T  = 4;
  localparam int TO_T    = 20;
`ifdef GESTURE_LOCK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] hand = 2'b00;
  logic       r, g, unlock;
  logic [2:0] step;

  gesture_lock_fsm #(
    .CLK_HZ            (CLK_HZ),
    .TICK_HZ           (TICK_HZ),
    .SEQ_LEN           (SEQ_LEN),
    .PATTERN           (8'b00_11_01_11),
    .DEBOUNCE_TICKS    (DEB),
    .ARM_TICKS         (ARM_T),
    .OPEN_TICKS        (OPEN_T),
    .FAIL_TICKS        (FAIL_T),
    .STEP_TIMEOUT_TICKS(TO_T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hand  (hand),
    .r     (r),
    .g     (g),
    .unlock(unlock),
    .step  (step)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_tick = -1;
  int ulk_cnt = 0;
  int tot_ulk = 0;
  int n_ticks = 0;

  // Gesture sequence as written out in plain order.
  logic [1:0] seq [SEQ_LEN] = '{2'b11, 2'b01, 2'b11, 2'b00};

  // Behavioural model: tick-level, countdown phases, sample history window.
  logic [1:0] m_hist [$];
  logic [1:0] m_dh;
  string      m_mode;
  int         m_idx;
  int         m_left;
  bit         m_r;
  bit         m_unlock_exp;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", tag, got, exp, n_ticks);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
    cyc++;
    if (unlock) begin
      ulk_cnt++;
      tot_ulk++;
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_dh = 2'b00;
    m_mode = "idle";
    m_idx = 0;
    m_left = 0;
    m_r = 1'b1;
    m_unlock_exp = 1'b0;
  endtask

  task automatic model_fail();
    m_mode = "fail";
    m_left = FAIL_T;
    m_r = 1'b1;
  endtask

  task automatic model_tick(input logic [1:0] h);
    bit ev;
    ev = 1'b0;
    m_unlock_exp = 1'b0;
    m_hist.push_back(h);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    if (m_hist.size() == DEB && h != m_dh) begin
      ev = 1'b1;
      foreach (m_hist[i]) if (m_hist[i] != h) ev = 1'b0;
    end
    if (ev) m_dh = h;

    if (m_mode == "idle") begin
      if (ev && h == seq[0]) begin
        m_mode = "match";
        m_idx = 1;
        m_left = TO_T;
        m_r = 1'b0;
      end
    end else if (m_mode == "match") begin
      if (ev) begin
        if (h == seq[m_idx]) begin
          if (m_idx == SEQ_LEN - 1) begin
            m_mode = "arm";
            m_left = ARM_T;
            m_r = 1'b1;
          end else begin
            m_idx++;
            m_left = TO_T;
          end
        end else begin
          model_fail();
        end
      end else if (TO_EN) begin
        m_left--;
        if (m_left == 0) model_fail();
      end
    end else if (m_mode == "arm") begin
      m_left--;
      if (m_left == 0) begin
        m_mode = "open";
        m_left = OPEN_T;
        m_r = 1'b0;
        m_unlock_exp = 1'b1;
      end
    end else if (m_mode == "open") begin
      m_left--;
      if (m_left == 0) begin
        m_mode = "idle";
        m_idx = 0;
        m_r = 1'b1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_mode = "idle";
        m_idx = 0;
        m_r = 1'b1;
      end else begin
        m_r = !m_r;
      end
    end
  endtask

  // Present h for one tick period, then compare outputs just after the tick.
  task automatic run_tick(input logic [1:0] h);
    bit seen;
    seen = 1'b0;
    hand = h;
    ulk_cnt = 0;
    for (int i = 0; i < 3 * DIV && !seen; i++) begin
      nclk();
      if (dut.u_tick.tick) seen = 1'b1;
    end
    if (!seen) begin
      check_eq("tick_seen", 0, 1);
      return;
    end
    if (last_tick >= 0) check_eq("tick_gap", cyc - last_tick, DIV);
    last_tick = cyc;
    nclk();
    n_ticks++;
    model_tick(h);
    check_eq("r", int'(r), int'(m_r));
    check_eq("g", int'(g), int'(m_mode == "open"));
    check_eq("unlock_pulse", ulk_cnt, int'(m_unlock_exp));
    if (m_mode == "idle" || m_mode == "match") check_eq("step", int'(step), m_idx);
  endtask

  task automatic hold(input logic [1:0] h, input int n);
    for (int i = 0; i < n; i++) run_tick(h);
  endtask

  initial begin
    int k;
    model_reset();
    reset = 1'b1;
    hand = 2'b00;
    repeat (3) nclk();
    check_eq("rst_r", int'(r), 1);
    check_eq("rst_g", int'(g), 0);
    check_eq("rst_unlock", int'(unlock), 0);
    check_eq("rst_step", int'(step), 0);
    reset = 1'b0;
    last_tick = -1;

    // One-tick glitch in IDLE must not be accepted.
    hold(2'b00, 3);
    hold(2'b11, 1);
    hold(2'b00, 4);
    check_eq("glitch_step", int'(step), 0);

    // Full sequence, 5 ticks per gesture, then ARM and OPEN run out.
    tot_ulk = 0;
    foreach (seq[i]) hold(seq[i], 5);
    hold(2'b00, 20);
    check_eq("seq_unlock_total", tot_ulk, 1);
    check_eq("seq_back_idle_r", int'(r), 1);

    // Wrong second gesture -> FAIL, no unlock.
    tot_ulk = 0;
    hold(2'b11, 3);
    hold(2'b10, 8);
    check_eq("wrong_unlock_total", tot_ulk, 0);
    check_eq("wrong_step", int'(step), 0);

    // Long hold after first gesture: timeout only when the macro is defined.
    hold(2'b11, 25);
    hold(2'b00, 8);

    // Event landing on the ARM exit tick: OPEN only.
    hold(2'b11, 5);
    hold(2'b01, 5);
    hold(2'b11, 5);
    hold(2'b00, 5);
    hold(2'b01, 2);
    check_eq("coinc_g", int'(g), 1);
    check_eq("coinc_r", int'(r), 0);
    hold(2'b01, 12);

    // Reset in OPEN tick 3, then a normal unlock.
    hold(2'b11, 5);
    hold(2'b01, 5);
    hold(2'b11, 5);
    k = 0;
    while (m_mode != "open" && k < 20) begin
      run_tick(2'b00);
      k++;
    end
    check_eq("reached_open", int'(m_mode == "open"), 1);
    hold(2'b00, 3);
    nclk();
    nclk();
    ulk_cnt = 0;
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_r", int'(r), 1);
    check_eq("midrst_g", int'(g), 0);
    check_eq("midrst_step", int'(step), 0);
    nclk();
    nclk();
    check_eq("midrst_no_unlock", ulk_cnt, 0);
    reset = 1'b0;
    model_reset();
    last_tick = -1;
    tot_ulk = 0;
    foreach (seq[i]) hold(seq[i], 4);
    hold(2'b00, 18);
    check_eq("post_rst_unlock_total", tot_ulk, 1);

    // Randomised traffic: sequences, corrupted sequences and noise.
    for (int it = 0; it < 40; it++) begin
      int mode;
      int bad_at;
      mode = $urandom_range(0, 2);
      bad_at = $urandom_range(0, SEQ_LEN - 1);
      hold(2'b00, $urandom_range(2, 3));
      if (mode == 2) begin
        for (int j = 0; j < 6; j++) hold(2'($urandom_range(0, 3)), $urandom_range(1, 3));
      end else begin
        for (int j = 0; j < SEQ_LEN; j++) begin
          logic [1:0] hv;
          hv = seq[j];
          if (mode == 1 && j == bad_at) hv = 2'($urandom_range(0, 3));
          hold(hv, $urandom_range(2, 4));
        end
      end
      hold(2'($urandom_range(0, 3)), $urandom_range(2, 16));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
